// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - opcode/flag inputs and datapath control outputs of the multicycle MIPS controller
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state_out;

    // Controller side
    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero, alu_op,
               pc_source, illegal_op, state_out
    );

    // Datapath side
    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero, alu_op,
               pc_source, illegal_op, state_out
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM for the multicycle MIPS datapath
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_ANDI  = 6'b001100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_multicycle_control_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ANDIEX = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t     state_q;
    state_t     state_d;

    // Internal enables folded into pc_en
    logic       pc_write;
    logic       branch;

    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;

    // State register; reset returns to instruction fetch immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; every output defaults to 0, reset masks them all
    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Read instruction at PC while the ALU computes PC+4
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively compute the branch target PC + (imm << 2)
                alu_src_b = 2'b11;
                alu_op    = 2'b00;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEXE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b00;
                state_d   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                // Write request stays a level until memory accepts it
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                state_d   = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                // Compare A and B; the PC loads the target only when they match
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b00;
                state_d   = S_IMMWB;
            end
            S_ANDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_zero  = 1'b1;
                alu_op    = 2'b11;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // Unused encodings recover through fetch with quiet outputs
                state_d = S_FETCH;
            end
        endcase

        pc_en = pc_write | (branch & bus.zero);

        // No enable or request may be seen by the datapath while reset is high
        if (reset) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            pc_en      = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            mem_to_reg = 1'b0;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            ext_zero   = 1'b0;
            alu_op     = 2'b00;
            pc_source  = 2'b00;
            illegal_op = 1'b0;
            state_d    = S_FETCH;
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.i_or_d     = i_or_d;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_dst    = reg_dst;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ext_zero   = ext_zero;
    assign bus.alu_op     = alu_op;
    assign bus.pc_source  = pc_source;
    assign bus.illegal_op = illegal_op;
    assign bus.state_out  = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - vector table plus randomized reference-model bench for mips_multicycle_control
module tb_mips_multicycle_control;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    // Bit order: pc_en i_or_d mem_read mem_write ir_write mem_to_reg reg_dst reg_write
    //            alu_src_a alu_src_b[2] ext_zero alu_op[2] pc_source[2] illegal_op
    localparam logic [16:0] O_ZERO   = 17'b0_0_0_0_0_0_0_0_0_00_0_00_00_0;
    localparam logic [16:0] O_FRDY   = 17'b1_0_1_0_1_0_0_0_0_01_0_00_00_0;
    localparam logic [16:0] O_FWAIT  = 17'b0_0_1_0_0_0_0_0_0_01_0_00_00_0;
    localparam logic [16:0] O_DEC    = 17'b0_0_0_0_0_0_0_0_0_11_0_00_00_0;
    localparam logic [16:0] O_DECILL = 17'b0_0_0_0_0_0_0_0_0_11_0_00_00_1;
    localparam logic [16:0] O_MADR   = 17'b0_0_0_0_0_0_0_0_1_10_0_00_00_0;
    localparam logic [16:0] O_MRD    = 17'b0_1_1_0_0_0_0_0_0_00_0_00_00_0;
    localparam logic [16:0] O_MWB    = 17'b0_0_0_0_0_1_0_1_0_00_0_00_00_0;
    localparam logic [16:0] O_MWR    = 17'b0_1_0_1_0_0_0_0_0_00_0_00_00_0;
    localparam logic [16:0] O_RTEX   = 17'b0_0_0_0_0_0_0_0_1_00_0_10_00_0;
    localparam logic [16:0] O_ALUWB  = 17'b0_0_0_0_0_0_1_1_0_00_0_00_00_0;
    localparam logic [16:0] O_BR1    = 17'b1_0_0_0_0_0_0_0_1_00_0_01_01_0;
    localparam logic [16:0] O_BR0    = 17'b0_0_0_0_0_0_0_0_1_00_0_01_01_0;
    localparam logic [16:0] O_ADDI   = 17'b0_0_0_0_0_0_0_0_1_10_0_00_00_0;
    localparam logic [16:0] O_ANDI   = 17'b0_0_0_0_0_0_0_0_1_10_1_11_00_0;
    localparam logic [16:0] O_IMMWB  = 17'b0_0_0_0_0_0_0_1_0_00_0_00_00_0;
    localparam logic [16:0] O_JUMP   = 17'b1_0_0_0_0_0_0_0_0_00_0_00_10_0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    vec_t tv[$];

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] act_out;
    assign act_out = {bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                      bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                      bus.alu_src_b, bus.ext_zero, bus.alu_op, bus.pc_source,
                      bus.illegal_op};

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: state/outputs got %h_%05h, expected %h_%05h",
                     name, act[20:17], act[16:0], exp[20:17], exp[16:0]);
        end
    endtask

    task automatic add(input logic rst, input logic [5:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [16:0] out);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.out = out;
        tv.push_back(v);
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) ||
               (op == ADDI) || (op == ANDI) || (op == JMP);
    endfunction

    // Expected control word for a state number under the current inputs
    function automatic logic [16:0] exp_out(input logic [3:0] st, input logic rdy,
                                            input logic z, input logic [5:0] op);
        case (st)
            4'd0:    return rdy ? O_FRDY : O_FWAIT;
            4'd1:    return is_legal(op) ? O_DEC : O_DECILL;
            4'd2:    return O_MADR;
            4'd3:    return O_MRD;
            4'd4:    return O_MWB;
            4'd5:    return O_MWR;
            4'd6:    return O_RTEX;
            4'd7:    return O_ALUWB;
            4'd8:    return z ? O_BR1 : O_BR0;
            4'd9:    return O_ADDI;
            4'd10:   return O_ANDI;
            4'd11:   return O_IMMWB;
            4'd12:   return O_JUMP;
            default: return O_ZERO;
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 8))
            0: return LW;
            1: return SW;
            2: return RT;
            3: return BEQ;
            4: return ADDI;
            5: return ANDI;
            6: return JMP;
            default: return 6'($urandom);
        endcase
    endfunction

    logic [3:0] m_st;
    int         rest[$];
    logic       r;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.opcode    = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset, then lw with memory always ready: 0,1,2,3,4
        add(1, LW, 0, 1, 4'd0, O_ZERO);
        add(0, LW, 0, 1, 4'd0, O_FRDY);
        add(0, LW, 1, 1, 4'd1, O_DEC);
        add(0, LW, 1, 1, 4'd2, O_MADR);
        add(0, LW, 1, 1, 4'd3, O_MRD);
        add(0, LW, 0, 1, 4'd4, O_MWB);
        // R-type, then andi
        add(0, RT, 1, 1, 4'd0, O_FRDY);
        add(0, RT, 0, 1, 4'd1, O_DEC);
        add(0, LW, 1, 1, 4'd6, O_RTEX);
        add(0, SW, 0, 1, 4'd7, O_ALUWB);
        add(0, ANDI, 0, 1, 4'd0, O_FRDY);
        add(0, ANDI, 0, 1, 4'd1, O_DEC);
        add(0, BAD, 1, 1, 4'd10, O_ANDI);
        add(0, RT, 0, 1, 4'd11, O_IMMWB);
        // beq taken, then not taken
        add(0, BEQ, 0, 1, 4'd0, O_FRDY);
        add(0, BEQ, 0, 1, 4'd1, O_DEC);
        add(0, BEQ, 1, 1, 4'd8, O_BR1);
        add(0, BEQ, 1, 1, 4'd0, O_FRDY);
        add(0, BEQ, 1, 1, 4'd1, O_DEC);
        add(0, BEQ, 0, 1, 4'd8, O_BR0);
        // sw with three wait cycles in MEMWR
        add(0, SW, 0, 1, 4'd0, O_FRDY);
        add(0, SW, 0, 1, 4'd1, O_DEC);
        add(0, SW, 0, 0, 4'd2, O_MADR);
        add(0, SW, 0, 0, 4'd5, O_MWR);
        add(0, LW, 1, 0, 4'd5, O_MWR);
        add(0, RT, 0, 0, 4'd5, O_MWR);
        add(0, SW, 0, 1, 4'd5, O_MWR);
        // Fetch with two wait cycles, then an illegal opcode
        add(0, BAD, 0, 0, 4'd0, O_FWAIT);
        add(0, BAD, 1, 0, 4'd0, O_FWAIT);
        add(0, BAD, 0, 1, 4'd0, O_FRDY);
        add(0, BAD, 0, 1, 4'd1, O_DECILL);
        // Jump
        add(0, JMP, 0, 1, 4'd0, O_FRDY);
        add(0, JMP, 0, 1, 4'd1, O_DEC);
        add(0, BAD, 0, 1, 4'd12, O_JUMP);
        // addi, then lw interrupted by reset while waiting in MEMRD
        add(0, ADDI, 0, 1, 4'd0, O_FRDY);
        add(0, ADDI, 0, 1, 4'd1, O_DEC);
        add(0, ADDI, 0, 1, 4'd9, O_ADDI);
        add(0, ADDI, 0, 1, 4'd11, O_IMMWB);
        add(0, LW, 0, 1, 4'd0, O_FRDY);
        add(0, LW, 0, 1, 4'd1, O_DEC);
        add(0, LW, 0, 0, 4'd2, O_MADR);
        add(0, LW, 0, 0, 4'd3, O_MRD);
        add(0, LW, 0, 0, 4'd3, O_MRD);
        add(1, LW, 1, 1, 4'd0, O_ZERO);
        add(0, LW, 0, 1, 4'd0, O_FRDY);
        add(0, LW, 0, 1, 4'd1, O_DEC);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            reset         = tv[i].rst;
            bus.opcode    = tv[i].op;
            bus.zero      = tv[i].z;
            bus.mem_ready = tv[i].rdy;
            #1;
            check($sformatf("vec%0d", i), {bus.state_out, act_out}, {tv[i].st, tv[i].out});
        end

        // Randomized run against the instruction-path model
        m_st = 4'd0;
        rest.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = (c == 0) || ($urandom_range(0, 63) == 0);
            reset = r;
            if (m_st != 4'd2) bus.opcode = pick_op();
            bus.zero      = 1'($urandom_range(0, 1));
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (r) begin
                m_st = 4'd0;
                rest.delete();
                check($sformatf("rnd%0d", c), {bus.state_out, act_out}, {4'd0, O_ZERO});
            end else begin
                check($sformatf("rnd%0d", c), {bus.state_out, act_out},
                      {m_st, exp_out(m_st, bus.mem_ready, bus.zero, bus.opcode)});
                // Advance along the remaining state path of the current instruction
                case (m_st)
                    4'd0: if (bus.mem_ready) m_st = 4'd1;
                    4'd1: begin
                        rest.delete();
                        case (bus.opcode)
                            LW:   begin rest.push_back(2); rest.push_back(3); rest.push_back(4); end
                            SW:   begin rest.push_back(2); rest.push_back(5); end
                            RT:   begin rest.push_back(6); rest.push_back(7); end
                            BEQ:  rest.push_back(8);
                            ADDI: begin rest.push_back(9); rest.push_back(11); end
                            ANDI: begin rest.push_back(10); rest.push_back(11); end
                            JMP:  rest.push_back(12);
                            default: ;
                        endcase
                        m_st = (rest.size() > 0) ? 4'(rest.pop_front()) : 4'd0;
                    end
                    4'd3, 4'd5: if (bus.mem_ready)
                        m_st = (rest.size() > 0) ? 4'(rest.pop_front()) : 4'd0;
                    default: m_st = (rest.size() > 0) ? 4'(rest.pop_front()) : 4'd0;
                endcase
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
